// File: rtl/jump_game_ctrl.sv
// jump_game_ctrl: jump game sequencer (button conditioning, charge cap, jump watchdog, landing judge, score).
// Optional button debounce is enabled by defining JUMP_GAME_DEBOUNCE_EN.
`timescale 1ns/1ps

module jump_game_ctrl #(
    parameter logic [23:0] ACCU_MAX     = 24'd16_000_000,
    parameter logic [23:0] JUMP_TIMEOUT = 24'd12_500_000,
    parameter logic [19:0] DEBOUNCE_CYC = 20'd250_000
) (
    input  logic       clk_machine,
    input  logic       rst_machine,
    input  logic       i_btn,
    input  logic       i_jump_done,
    input  logic       i_land_ok,
    output logic [2:0] o_state,
    output logic       o_btn,
    output logic       o_scene_init,
    output logic       o_jump_start,
    output logic [7:0] o_score,
    output logic       o_game_over
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INIT  = 3'd1;
    localparam logic [2:0] ST_READY = 3'd2;
    localparam logic [2:0] ST_ACCU  = 3'd3;
    localparam logic [2:0] ST_JUMP  = 3'd4;
    localparam logic [2:0] ST_LAND  = 3'd5;
    localparam logic [2:0] ST_OVER  = 3'd6;

    logic        btn_s1;
    logic        btn_s2;
    logic        btn_lvl;
    logic        btn_dly;
    logic        btn_rise;
    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [23:0] phase_cnt;
    logic        land_ok_q;
    logic        jump_start_q;
    logic [7:0]  score;

    always_ff @(posedge clk_machine or negedge rst_machine) begin
        if (!rst_machine) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
        end else begin
            btn_s1 <= i_btn;
            btn_s2 <= btn_s1;
        end
    end

`ifdef JUMP_GAME_DEBOUNCE_EN
    logic [19:0] db_cnt;
    logic        btn_db;

    // Level is accepted only after DEBOUNCE_CYC consecutive disagreeing cycles.
    always_ff @(posedge clk_machine or negedge rst_machine) begin
        if (!rst_machine) begin
            db_cnt <= '0;
            btn_db <= 1'b0;
        end else if (btn_s2 == btn_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DEBOUNCE_CYC - 20'd1) begin
            db_cnt <= '0;
            btn_db <= btn_s2;
        end else begin
            db_cnt <= db_cnt + 20'd1;
        end
    end

    assign btn_lvl = btn_db;
`else
    // Keeps the parameter list identical in both builds.
    logic unused_debounce_cfg;
    assign unused_debounce_cfg = ^DEBOUNCE_CYC;
    assign btn_lvl = btn_s2;
`endif

    always_ff @(posedge clk_machine or negedge rst_machine) begin
        if (!rst_machine) btn_dly <= 1'b0;
        else              btn_dly <= btn_lvl;
    end

    assign btn_rise = btn_lvl & ~btn_dly;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (btn_rise) state_nxt = ST_INIT;
            ST_INIT:  state_nxt = ST_READY;
            ST_READY: if (btn_rise) state_nxt = ST_ACCU;
            ST_ACCU:  if (!btn_lvl || phase_cnt == ACCU_MAX - 24'd1) state_nxt = ST_JUMP;
            ST_JUMP: begin
                if (i_jump_done)                              state_nxt = ST_LAND;
                else if (phase_cnt == JUMP_TIMEOUT - 24'd1)   state_nxt = ST_OVER;
            end
            ST_LAND:  state_nxt = land_ok_q ? ST_READY : ST_OVER;
            ST_OVER:  if (btn_rise) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // One counter serves both the charge cap and the jump watchdog; it restarts on every state change.
    always_ff @(posedge clk_machine or negedge rst_machine) begin
        if (!rst_machine) begin
            state        <= ST_IDLE;
            phase_cnt    <= '0;
            land_ok_q    <= 1'b0;
            jump_start_q <= 1'b0;
            score        <= '0;
        end else begin
            state        <= state_nxt;
            phase_cnt    <= (state_nxt != state) ? '0 : phase_cnt + 24'd1;
            jump_start_q <= (state == ST_ACCU) && (state_nxt == ST_JUMP);
            if (state == ST_JUMP && i_jump_done)
                land_ok_q <= i_land_ok;
            if (state_nxt == ST_INIT)
                score <= '0;
            else if (state == ST_LAND && land_ok_q && score != 8'hFF)
                score <= score + 8'd1;
        end
    end

    assign o_state      = state;
    assign o_btn        = btn_lvl;
    assign o_scene_init = (state == ST_INIT);
    assign o_jump_start = jump_start_q;
    assign o_score      = score;
    assign o_game_over  = (state == ST_OVER);

endmodule

// File: tb/tb_jump_game_ctrl.sv
// Self-checking bench for jump_game_ctrl: randomized rounds against a round-level game model.
`timescale 1ns/1ps

module tb_jump_game_ctrl;

    localparam int ACCU_MAX     = 100;
    localparam int JUMP_TIMEOUT = 50;
    localparam int DEBOUNCE_CYC = 4;
`ifdef JUMP_GAME_DEBOUNCE_EN
    localparam int BTN_LAT = 2 + DEBOUNCE_CYC;
`else
    localparam int BTN_LAT = 2;
`endif

    logic       clk_machine = 1'b0;
    logic       rst_machine = 1'b0;
    logic       i_btn       = 1'b0;
    logic       i_jump_done = 1'b0;
    logic       i_land_ok   = 1'b0;
    logic [2:0] o_state;
    logic       o_btn;
    logic       o_scene_init;
    logic       o_jump_start;
    logic [7:0] o_score;
    logic       o_game_over;

    jump_game_ctrl #(
        .ACCU_MAX    (24'd100),
        .JUMP_TIMEOUT(24'd50),
        .DEBOUNCE_CYC(20'd4)
    ) dut (
        .clk_machine (clk_machine),
        .rst_machine (rst_machine),
        .i_btn       (i_btn),
        .i_jump_done (i_jump_done),
        .i_land_ok   (i_land_ok),
        .o_state     (o_state),
        .o_btn       (o_btn),
        .o_scene_init(o_scene_init),
        .o_jump_start(o_jump_start),
        .o_score     (o_score),
        .o_game_over (o_game_over)
    );

    always #20 clk_machine = ~clk_machine;

    int checks = 0;
    int errors = 0;
    int sc_model = 0;
    int jumps_model = 0;
    int inits_model = 0;
    int js_cnt = 0, si_cnt = 0, js_long = 0, si_long = 0, overlap = 0;
    logic js_prev = 1'b0, si_prev = 1'b0;

    // Pulse bookkeeping, compared against the model in test_pulses.
    always @(negedge clk_machine) begin
        if (rst_machine) begin
            if (o_jump_start) js_cnt++;
            if (o_scene_init) si_cnt++;
            if (o_jump_start && js_prev) js_long++;
            if (o_scene_init && si_prev) si_long++;
            if (o_jump_start && o_scene_init) overlap++;
            js_prev = o_jump_start;
            si_prev = o_scene_init;
        end else begin
            js_prev = 1'b0;
            si_prev = 1'b0;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not complete within 5 ms");
        $fatal(1);
    end

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic tick;
        @(posedge clk_machine);
        #1;
    endtask

    task automatic press_until_change(output int n);
        logic [2:0] s0;
        s0 = o_state;
        i_btn = 1'b1;
        n = 0;
        do begin
            tick;
            n++;
        end while (o_state == s0 && n < 40);
    endtask

    task automatic release_btn;
        i_btn = 1'b0;
        repeat (BTN_LAT + 1) tick;
    endtask

    task automatic start_game;
        int n;
        press_until_change(n);
        checks++; if (n !== BTN_LAT + 1) begin errors++; $display("FAIL start_latency: got %0d exp %0d", n, BTN_LAT + 1); end
        checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL start_init_state: got %0d exp 1", o_state); end
        checks++; if (o_scene_init !== 1'b1) begin errors++; $display("FAIL start_scene_init: got %b exp 1", o_scene_init); end
        checks++; if (o_score !== 8'd0) begin errors++; $display("FAIL start_score_clear: got %0d exp 0", o_score); end
        inits_model++;
        sc_model = 0;
        release_btn;
        checks++; if (o_state !== 3'd2) begin errors++; $display("FAIL start_ready: got %0d exp 2", o_state); end
    endtask

    task automatic restart_from_over;
        int n;
        press_until_change(n);
        checks++; if (n !== BTN_LAT + 1) begin errors++; $display("FAIL over_exit_latency: got %0d exp %0d", n, BTN_LAT + 1); end
        checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL over_to_idle: got %0d exp 0", o_state); end
        checks++; if (o_game_over !== 1'b0) begin errors++; $display("FAIL idle_game_over: got %b exp 0", o_game_over); end
        release_btn;
        start_game;
    endtask

    // One round from READY: charge for press_len raw cycles, physics reports done after done_at JUMP cycles.
    task automatic play_round(input int press_len, input int done_at, input bit ok, output bit over_exp);
        int t;
        int accu;
        int exp_t;
        logic [2:0] exp_end;
        i_btn = 1'b1;
        t = 0;
        accu = 0;
        while (o_state != 3'd4 && t < 400) begin
            tick;
            t++;
            if (t == press_len) i_btn = 1'b0;
            if (o_state == 3'd3) accu++;
        end
        checks++; if (o_state !== 3'd4) begin errors++; $display("FAIL round_enter_jump: got %0d exp 4", o_state); end
        checks++; if (accu !== imin(press_len, ACCU_MAX)) begin errors++; $display("FAIL round_accu_len: got %0d exp %0d", accu, imin(press_len, ACCU_MAX)); end
        checks++; if (o_jump_start !== 1'b1) begin errors++; $display("FAIL round_jump_start: got %b exp 1", o_jump_start); end
        jumps_model++;

        t = 0;
        while (o_state == 3'd4 && t < 200) begin
            i_jump_done = (t == done_at);
            i_land_ok   = (t == done_at) ? ok : 1'($urandom);
            tick;
            t++;
        end
        i_jump_done = 1'b0;
        i_land_ok   = 1'b0;
        exp_t   = (done_at < JUMP_TIMEOUT) ? done_at + 1 : JUMP_TIMEOUT;
        exp_end = (done_at < JUMP_TIMEOUT && ok) ? 3'd2 : 3'd6;
        checks++; if (t !== exp_t) begin errors++; $display("FAIL round_jump_len: got %0d exp %0d", t, exp_t); end
        checks++; if (o_state !== ((done_at < JUMP_TIMEOUT) ? 3'd5 : 3'd6)) begin
            errors++; $display("FAIL round_after_jump: got %0d exp %0d", o_state, (done_at < JUMP_TIMEOUT) ? 5 : 6);
        end
        if (done_at < JUMP_TIMEOUT) begin
            tick;
            if (ok) sc_model = imin(sc_model + 1, 255);
        end
        checks++; if (o_state !== exp_end) begin errors++; $display("FAIL round_end_state: got %0d exp %0d", o_state, exp_end); end
        checks++; if (o_score !== 8'(sc_model)) begin errors++; $display("FAIL round_score: got %0d exp %0d", o_score, sc_model); end
        checks++; if (o_game_over !== (exp_end == 3'd6)) begin errors++; $display("FAIL round_game_over: got %b exp %b", o_game_over, exp_end == 3'd6); end
        i_btn = 1'b0;
        repeat (BTN_LAT + 2) tick;
        checks++; if (o_state !== exp_end) begin errors++; $display("FAIL round_no_recharge: got %0d exp %0d", o_state, exp_end); end
        over_exp = (exp_end == 3'd6);
    endtask

    task automatic test_reset;
        rst_machine = 1'b0;
        i_btn = 1'b0;
        i_jump_done = 1'b0;
        i_land_ok = 1'b0;
        repeat (3) tick;
        checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", o_state); end
        checks++; if (o_score !== 8'd0) begin errors++; $display("FAIL reset_score: got %0d exp 0", o_score); end
        checks++; if ({o_scene_init, o_jump_start, o_game_over} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses: got %b exp 000", {o_scene_init, o_jump_start, o_game_over});
        end
        i_btn = 1'b1;
        repeat (3) tick;
        checks++; if (o_btn !== 1'b0) begin errors++; $display("FAIL reset_sync_held: got %b exp 0", o_btn); end
        i_btn = 1'b0;
        rst_machine = 1'b1;
        repeat (3) tick;
    endtask

`ifdef JUMP_GAME_DEBOUNCE_EN
    task automatic test_debounce;
        int hi;
        int first;
        i_btn = 1'b1;
        repeat (3) tick;
        i_btn = 1'b0;
        hi = 0;
        repeat (12) begin
            tick;
            if (o_btn) hi++;
        end
        checks++; if (hi !== 0) begin errors++; $display("FAIL debounce_glitch: got %0d high cycles exp 0", hi); end
        checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL debounce_glitch_state: got %0d exp 0", o_state); end
        i_btn = 1'b1;
        first = -1;
        for (int k = 1; k <= 20; k++) begin
            tick;
            if (k == 6) i_btn = 1'b0;
            if (o_btn && first < 0) first = k;
        end
        checks++; if (first !== 2 + DEBOUNCE_CYC) begin errors++; $display("FAIL debounce_rise: got %0d exp %0d", first, 2 + DEBOUNCE_CYC); end
        inits_model++;
        test_reset;
    endtask
`endif

    task automatic test_normal_round;
        bit ov;
        start_game;
        play_round(20, $urandom_range(0, 20), 1'b1, ov);
        checks++; if (o_score !== 8'd1) begin errors++; $display("FAIL normal_score: got %0d exp 1", o_score); end
    endtask

    task automatic test_forced;
        bit ov;
        play_round(150, 5, 1'b1, ov);
        play_round(ACCU_MAX, 3, 1'b1, ov);
        play_round(ACCU_MAX - 1, 3, 1'b1, ov);
    endtask

    task automatic test_watchdog;
        bit ov;
        play_round($urandom_range(8, 60), JUMP_TIMEOUT - 1, 1'b1, ov);
        play_round($urandom_range(8, 60), JUMP_TIMEOUT + 10, 1'b1, ov);
        checks++; if (o_game_over !== 1'b1) begin errors++; $display("FAIL watchdog_over: got %b exp 1", o_game_over); end
    endtask

    task automatic test_over_restart;
        restart_from_over;
    endtask

    task automatic test_land_fail;
        bit ov;
        play_round($urandom_range(8, 60), $urandom_range(0, 40), 1'b1, ov);
        play_round($urandom_range(8, 60), $urandom_range(0, 40), 1'b0, ov);
        checks++; if (o_score !== 8'd1) begin errors++; $display("FAIL land_fail_score: got %0d exp 1", o_score); end
        restart_from_over;
    endtask

    task automatic test_saturation;
        bit ov;
        for (int r = 0; r < 260; r++)
            play_round($urandom_range(8, 110), $urandom_range(0, 49), 1'b1, ov);
        checks++; if (o_score !== 8'd255) begin errors++; $display("FAIL saturation_score: got %0d exp 255", o_score); end
    endtask

    task automatic test_random;
        bit ov;
        restart_from_over_if_needed(1'b0);
        for (int r = 0; r < 25; r++) begin
            play_round($urandom_range(8, 120), $urandom_range(0, 60), ($urandom_range(0, 3) != 0), ov);
            if (ov) restart_from_over;
        end
    endtask

    task automatic restart_from_over_if_needed(input bit in_over);
        if (in_over) restart_from_over;
    endtask

    task automatic test_reset_mid_accu;
        bit ov;
        int js0;
        play_round($urandom_range(8, 40), $urandom_range(0, 20), 1'b1, ov);
        if (ov) restart_from_over;
        play_round(10, 2, 1'b1, ov);
        i_btn = 1'b1;
        repeat (BTN_LAT + 1 + 30) tick;
        checks++; if (o_state !== 3'd3) begin errors++; $display("FAIL mid_accu_pre: got %0d exp 3", o_state); end
        js0 = js_cnt;
        #5;
        rst_machine = 1'b0;
        i_btn = 1'b0;
        #1;
        checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL mid_accu_state: got %0d exp 0", o_state); end
        checks++; if (o_score !== 8'd0) begin errors++; $display("FAIL mid_accu_score: got %0d exp 0", o_score); end
        checks++; if (o_jump_start !== 1'b0) begin errors++; $display("FAIL mid_accu_js: got %b exp 0", o_jump_start); end
        rst_machine = 1'b1;
        repeat (10) tick;
        checks++; if (js_cnt !== js0) begin errors++; $display("FAIL mid_accu_no_jump: got %0d pulses exp %0d", js_cnt, js0); end
        checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL mid_accu_idle: got %0d exp 0", o_state); end
    endtask

    task automatic test_pulses;
        checks++; if (js_cnt !== jumps_model) begin errors++; $display("FAIL jump_start_count: got %0d exp %0d", js_cnt, jumps_model); end
        checks++; if (si_cnt !== inits_model) begin errors++; $display("FAIL scene_init_count: got %0d exp %0d", si_cnt, inits_model); end
        checks++; if (js_long !== 0) begin errors++; $display("FAIL jump_start_width: got %0d long pulses exp 0", js_long); end
        checks++; if (si_long !== 0) begin errors++; $display("FAIL scene_init_width: got %0d long pulses exp 0", si_long); end
        checks++; if (overlap !== 0) begin errors++; $display("FAIL pulse_overlap: got %0d exp 0", overlap); end
    endtask

    initial begin
        test_reset;
`ifdef JUMP_GAME_DEBOUNCE_EN
        test_debounce;
`endif
        test_normal_round;
        test_forced;
        test_watchdog;
        test_over_restart;
        test_land_fail;
        test_saturation;
        test_random;
        test_reset_mid_accu;
        test_pulses;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jump_game_ctrl.md
Name: jump_game_ctrl

Overview:
- Top-level game sequencer for the jump game.
- Generates the 3-bit `state` code consumed by the velocity accumulator and the physics/render blocks.
- Conditions the player button, caps the charge time, watchdogs the jump, judges the landing and keeps the score.
- Sits between the button input, the physics engine (`i_jump_done`, `i_land_ok`) and all state-decoding datapath blocks.

Parameters:
- ACCU_MAX, 24'd16_000_000: max cycles in ACCU before a forced jump (~0.64 s at 25 MHz).
- JUMP_TIMEOUT, 24'd12_500_000: max cycles in JUMP without `i_jump_done` before game over.
- DEBOUNCE_CYC, 20'd250_000: stable-level cycles required by the debouncer (used only with the macro).

Ports:
- clk_machine  input  1  main clock, 25 MHz
- rst_machine  input  1  asynchronous reset, active-low; clock named clk_machine, reset named rst_machine
- i_btn  input  1  raw player button, asynchronous, active-high
- i_jump_done  input  1  physics: jump finished, 1-cycle pulse or level
- i_land_ok  input  1  physics: landing on a platform; valid in the cycle `i_jump_done` is high
- o_state  output  3  state code
- o_btn  output  1  conditioned button level, for the velocity accumulator's `i_btn`
- o_scene_init  output  1  1-cycle pulse: reset the scene
- o_jump_start  output  1  1-cycle pulse: launch the jump
- o_score  output  8  landings count, saturating
- o_game_over  output  1  high while in OVER

Behaviour:
- State codes: IDLE=0, INIT=1, READY=2, ACCU=3, JUMP=4, LAND=5, OVER=6. Code 7 is illegal and returns to IDLE on the next edge.
- Button path: 2-flop synchroniser, then optional debounce, giving `o_btn`. `btn_rise` = `o_btn` & ~`o_btn` delayed by 1 cycle.
- Reset (rst_machine=0, async) forces:
  - o_state=IDLE, o_score=0.
  - All pulses 0, o_game_over=0.
  - Synchroniser and debouncer flops 0.
  - Charge and watchdog counters 0.
- IDLE: on btn_rise go to INIT.
- INIT: exactly 1 cycle.
  - o_scene_init=1, o_score cleared to 0.
  - Next state READY.
- READY: on btn_rise go to ACCU.
  - A button still held from the previous jump does not start a charge; a fresh edge is required.
- ACCU: charge counter starts at 0 on entry and increments every cycle.
  - Leave when `o_btn`=0, or when the counter reaches ACCU_MAX-1 (forced release).
  - Either exit goes to JUMP with o_jump_start=1 during the first JUMP cycle.
  - Both exit conditions in the same cycle give a single transition and a single pulse.
- JUMP: watchdog starts at 0 on entry.
  - i_jump_done=1: go to LAND. Latch `i_land_ok` in the same cycle.
  - Watchdog reaches JUMP_TIMEOUT-1 with no done: go to OVER.
  - Done and timeout in the same cycle: done wins.
  - Button activity is ignored.
- LAND: exactly 1 cycle.
  - Latched ok=1: o_score += 1, saturating at 255, then go to READY.
  - Latched ok=0: go to OVER.
- OVER: o_game_over=1. On btn_rise go to IDLE. The next btn_rise restarts the game via INIT.
- Latency:
  - Raw button to `o_btn` is 2 cycles without debounce.
  - State changes are registered, visible 1 cycle after the condition.
  - o_jump_start coincides with o_state=JUMP in its first cycle.
- Pulses are never asserted for more than 1 cycle. o_scene_init and o_jump_start are never high together.

Optional Feature:
- Macro: JUMP_GAME_DEBOUNCE_EN.
- Defined:
  - `o_btn` updates only after the synchronised level has differed from `o_btn` for DEBOUNCE_CYC consecutive cycles.
  - The debounce counter clears on any agreement.
  - Added latency is DEBOUNCE_CYC cycles.
- Undefined: `o_btn` = synchroniser output directly; no debounce counter is synthesised.

Test Plan:
(Benches override to ACCU_MAX=100, JUMP_TIMEOUT=50, DEBOUNCE_CYC=4.)
- Reset mid-ACCU (btn held 30 cycles, then rst_machine low for 1 ns between edges) -> o_state=0, o_score=0 immediately, no o_jump_start.
- Normal round: press (IDLE→INIT→READY), press 20 cycles, release, i_jump_done=1 with i_land_ok=1 -> states 1,2,3,4,5,2 in order; o_scene_init 1 cycle; o_jump_start 1 cycle; o_score=1.
- Hold button 150 cycles in ACCU -> forced JUMP after exactly 100 ACCU cycles; one o_jump_start; no new ACCU entry until release and re-press.
- JUMP with no i_jump_done -> OVER after 50 cycles, o_game_over=1; i_jump_done and timeout in the same cycle -> LAND.
- Land fail (i_land_ok=0) -> OVER, score unchanged. Land ok 260 times -> o_score saturates at 255. btn_rise in OVER -> IDLE; next press -> INIT, score cleared.
- With JUMP_GAME_DEBOUNCE_EN: 3-cycle glitch on i_btn -> no o_btn change; 6-cycle press -> o_btn rises 4 cycles after the synchroniser output.
